// File: rtl/writeback_unit.sv
// Registered writeback stage: selects integer/FP results, extends load data,
// holds a load while memory is busy, and drives both register-file write ports.
module writeback_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              RegWriteW,
  input  logic              fRegWriteW,
  input  logic [1:0]        ResultSrcW,
  input  logic              fResultSrcW,
  input  logic [2:0]        funct3W,
  input  logic [XLEN-1:0]   PCPlus4W,
  input  logic [XLEN-1:0]   ALU_ResultW,
  input  logic [XLEN-1:0]   ReadDataW,
  input  logic [XLEN-1:0]   FPU_ResultW,
  input  logic [XLEN-1:0]   fReadDataW,
  input  logic              o_p_waitrequest,
  output logic [XLEN-1:0]   ResultW,
  output logic [XLEN-1:0]   fResultW,
  output logic [REG_AW-1:0] rd_out,
  output logic              we_out,
  output logic              fwe_out,
  output logic              stall_w,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic {S_PASS, S_WAIT} state_t;

  state_t              state;
  logic [REG_AW-1:0]   h_rd;
  logic                h_regw, h_fregw, h_fsrc;
  logic [1:0]          h_src, h_off;
  logic [2:0]          h_f3;

  logic                in_wait, mem_src, pend, commit, capture;
  logic [REG_AW-1:0]   c_rd;
  logic                c_regw, c_fregw, c_fsrc;
  logic [1:0]          c_src, c_off;
  logic [2:0]          c_f3;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [XLEN-1:0]     ld_ext, int_sel, fp_sel;

  assign in_wait = (state == S_WAIT);
  assign mem_src = (ResultSrcW == 2'b01) || fResultSrcW;
  assign pend    = in_wait || (valid_w && mem_src);
  // Gated by rst so upstream is never frozen while the stage is held in reset.
  assign stall_w = rst && pend && o_p_waitrequest;
  assign commit  = in_wait ? !o_p_waitrequest : (valid_w && !stall_w);
  assign capture = !in_wait && valid_w && mem_src && o_p_waitrequest;

  // While waiting, control comes from the hold registers; data stays live.
  assign c_rd    = in_wait ? h_rd    : rd_w;
  assign c_regw  = in_wait ? h_regw  : RegWriteW;
  assign c_fregw = in_wait ? h_fregw : fRegWriteW;
  assign c_src   = in_wait ? h_src   : ResultSrcW;
  assign c_fsrc  = in_wait ? h_fsrc  : fResultSrcW;
  assign c_f3    = in_wait ? h_f3    : funct3W;
  assign c_off   = in_wait ? h_off   : ALU_ResultW[1:0];

  assign ld_byte = ReadDataW[{c_off, 3'b000} +: 8];
  assign ld_half = c_off[1] ? ReadDataW[31:16] : ReadDataW[15:0];

  always_comb begin
    ld_ext = ReadDataW;
    case (c_f3)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = ReadDataW;
    endcase
  end

  always_comb begin
    int_sel = ALU_ResultW;
    case (c_src)
      2'b01:   int_sel = ld_ext;
      2'b10:   int_sel = PCPlus4W;
      default: int_sel = ALU_ResultW;
    endcase
  end

  assign fp_sel = c_fsrc ? fReadDataW : FPU_ResultW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_PASS;
      h_rd       <= '0;
      h_regw     <= 1'b0;
      h_fregw    <= 1'b0;
      h_src      <= 2'b00;
      h_fsrc     <= 1'b0;
      h_f3       <= 3'b000;
      h_off      <= 2'b00;
      ResultW    <= '0;
      fResultW   <= '0;
      rd_out     <= '0;
      we_out     <= 1'b0;
      fwe_out    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      we_out  <= 1'b0;
      fwe_out <= 1'b0;
      if (capture) begin
        state   <= S_WAIT;
        h_rd    <= rd_w;
        h_regw  <= RegWriteW;
        h_fregw <= fRegWriteW;
        h_src   <= ResultSrcW;
        h_fsrc  <= fResultSrcW;
        h_f3    <= funct3W;
        h_off   <= ALU_ResultW[1:0];
      end
      if (commit) begin
        state      <= S_PASS;
        ResultW    <= int_sel;
        fResultW   <= fp_sel;
        rd_out     <= c_rd;
        we_out     <= c_regw && (c_rd != '0);
        fwe_out    <= c_fregw;
        retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus queues expected commits,
// a negedge monitor checks every register-file strobe against the queue.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_w, RegWriteW, fRegWriteW, fResultSrcW, o_p_waitrequest;
  logic [4:0]  rd_w;
  logic [1:0]  ResultSrcW;
  logic [2:0]  funct3W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, FPU_ResultW, fReadDataW;
  logic [31:0] ResultW, fResultW, res4, fres4;
  logic [4:0]  rd_out, rd4;
  logic        we_out, fwe_out, stall_w, we4, fwe4, stall4;
  logic [31:0] retire_cnt;
  logic [3:0]  retire_cnt4;

  typedef struct {
    logic [31:0] res;
    logic [31:0] fres;
    logic [4:0]  rd;
    logic        we;
    logic        fwe;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;
  int   stall_cycles;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst(rst), .valid_w(valid_w), .rd_w(rd_w), .RegWriteW(RegWriteW),
    .fRegWriteW(fRegWriteW), .ResultSrcW(ResultSrcW), .fResultSrcW(fResultSrcW),
    .funct3W(funct3W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .FPU_ResultW(FPU_ResultW), .fReadDataW(fReadDataW),
    .o_p_waitrequest(o_p_waitrequest), .ResultW(ResultW), .fResultW(fResultW),
    .rd_out(rd_out), .we_out(we_out), .fwe_out(fwe_out), .stall_w(stall_w),
    .retire_cnt(retire_cnt)
  );

  writeback_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .valid_w(valid_w), .rd_w(rd_w), .RegWriteW(RegWriteW),
    .fRegWriteW(fRegWriteW), .ResultSrcW(ResultSrcW), .fResultSrcW(fResultSrcW),
    .funct3W(funct3W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .FPU_ResultW(FPU_ResultW), .fReadDataW(fReadDataW),
    .o_p_waitrequest(o_p_waitrequest), .ResultW(res4), .fResultW(fres4),
    .rd_out(rd4), .we_out(we4), .fwe_out(fwe4), .stall_w(stall4),
    .retire_cnt(retire_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    valid_w = 1'b0; rd_w = '0; RegWriteW = 1'b0; fRegWriteW = 1'b0;
    ResultSrcW = 2'b00; fResultSrcW = 1'b0; funct3W = 3'b000;
    o_p_waitrequest = 1'b0; PCPlus4W = 32'h0000_0100; ALU_ResultW = '0;
    ReadDataW = '0; FPU_ResultW = '0; fReadDataW = '0;
  endtask

  task automatic push(input logic [31:0] res, input logic [31:0] fres, input logic [4:0] rd,
                      input logic we, input logic fwe);
    exp_t e;
    e.res = res; e.fres = fres; e.rd = rd; e.we = we; e.fwe = fwe;
    q.push_back(e);
  endtask

  // Present one instruction with memory ready; it commits at the next edge.
  task automatic issue(input logic [4:0] rd, input logic rw, input logic frw,
                       input logic [1:0] src, input logic fsrc, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] fpu, input logic [31:0] fdat,
                       input logic [31:0] eres, input logic [31:0] efres,
                       input logic ewe, input logic efwe);
    valid_w = 1'b1; rd_w = rd; RegWriteW = rw; fRegWriteW = frw;
    ResultSrcW = src; fResultSrcW = fsrc; funct3W = f3; o_p_waitrequest = 1'b0;
    ALU_ResultW = alu; ReadDataW = rdat; FPU_ResultW = fpu; fReadDataW = fdat;
    if (ewe || efwe) push(eres, efres, rd, ewe, efwe);
    exp_cnt++;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst && (we_out || fwe_out)) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, we_out, fwe_out}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("we_out", {31'd0, we_out}, {31'd0, e.we});
        chk("fwe_out", {31'd0, fwe_out}, {31'd0, e.fwe});
        if (e.we) begin
          chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
          chk("ResultW", ResultW, e.res);
        end
        if (e.fwe) chk("fResultW", fResultW, e.fres);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b0;
    // A load facing a busy memory must not raise stall while in reset.
    valid_w = 1'b1; ResultSrcW = 2'b01; o_p_waitrequest = 1'b1;
    #1;
    chk("reset_stall", {31'd0, stall_w}, 32'd0);
    chk("reset_ResultW", ResultW, 32'd0);
    chk("reset_fResultW", fResultW, 32'd0);
    chk("reset_strobes", {30'd0, we_out, fwe_out}, 32'd0);
    chk("reset_cnt", retire_cnt, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // ALU result, single commit, strobe must be a one-cycle pulse.
    issue(5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 32'h0,
          32'h0000_1234, 32'h0, 1'b1, 1'b0);
    idle();
    @(posedge clk); #1;
    chk("we_pulse", {31'd0, we_out}, 32'd0);
    chk("cnt_first", retire_cnt, 32'd1);

    // Back-to-back loads with extension, plus PC+4 and reserved source.
    issue(5'd1, 1'b1, 1'b0, 2'b01, 1'b0, 3'b000, 32'h3, 32'h80FF_7F01, 32'h0, 32'h0,
          32'hFFFF_FF80, 32'h0, 1'b1, 1'b0);
    issue(5'd2, 1'b1, 1'b0, 2'b01, 1'b0, 3'b100, 32'h3, 32'h80FF_7F01, 32'h0, 32'h0,
          32'h0000_0080, 32'h0, 1'b1, 1'b0);
    issue(5'd3, 1'b1, 1'b0, 2'b01, 1'b0, 3'b001, 32'h2, 32'h80FF_7F01, 32'h0, 32'h0,
          32'hFFFF_80FF, 32'h0, 1'b1, 1'b0);
    issue(5'd4, 1'b1, 1'b0, 2'b01, 1'b0, 3'b101, 32'h1, 32'h80FF_7F01, 32'h0, 32'h0,
          32'h0000_7F01, 32'h0, 1'b1, 1'b0);
    issue(5'd6, 1'b1, 1'b0, 2'b01, 1'b0, 3'b011, 32'h1, 32'h80FF_7F01, 32'h0, 32'h0,
          32'h80FF_7F01, 32'h0, 1'b1, 1'b0);
    issue(5'd8, 1'b1, 1'b0, 2'b10, 1'b0, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0,
          32'h0000_0100, 32'h0, 1'b1, 1'b0);
    issue(5'd9, 1'b1, 1'b0, 2'b11, 1'b0, 3'b000, 32'h77, 32'h0, 32'h0, 32'h0,
          32'h0000_0077, 32'h0, 1'b1, 1'b0);
    idle();
    @(posedge clk); #1;
    chk("cnt_loads", retire_cnt, exp_cnt);

    // Load held for three busy cycles; live control is junk during the wait.
    stall_cycles = 0;
    push(32'hDEAD_BEEF, 32'h0, 5'd7, 1'b1, 1'b0);
    exp_cnt++;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i == 0) begin
        valid_w = 1'b1; rd_w = 5'd7; RegWriteW = 1'b1; ResultSrcW = 2'b01; funct3W = 3'b010;
      end else begin
        rd_w = 5'd3; RegWriteW = 1'b0; funct3W = 3'b000; ALU_ResultW = 32'h2;
      end
      o_p_waitrequest = (i < 3);
      if (i == 3) ReadDataW = 32'hDEAD_BEEF;
      #1;
      if (stall_w) stall_cycles++;
      @(posedge clk); #1;
    end
    chk("stall_cycles", stall_cycles, 32'd3);
    chk("cnt_wait", retire_cnt, exp_cnt);

    // x0 integer write suppressed but retired; FP x0 writable; dual write.
    issue(5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h1111, 32'h0, 32'h0, 32'h0,
          32'h0, 32'h0, 1'b0, 1'b0);
    idle();
    #1;
    chk("x0_we", {31'd0, we_out}, 32'd0);
    chk("x0_cnt", retire_cnt, exp_cnt);
    @(posedge clk); #1;
    issue(5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 32'h3F80_0000, 32'h0,
          32'h0, 32'h3F80_0000, 1'b0, 1'b1);
    issue(5'd3, 1'b1, 1'b1, 2'b00, 1'b1, 3'b000, 32'h55, 32'h0, 32'h0, 32'hC049_0FDB,
          32'h0000_0055, 32'hC049_0FDB, 1'b1, 1'b1);
    idle();
    @(posedge clk); #1;
    chk("cnt_fp", retire_cnt, exp_cnt);

    // Reset while waiting aborts the held load.
    valid_w = 1'b1; rd_w = 5'd9; RegWriteW = 1'b1; ResultSrcW = 2'b01; funct3W = 3'b010;
    o_p_waitrequest = 1'b1;
    @(posedge clk); #1;
    idle();
    o_p_waitrequest = 1'b1;
    #1;
    chk("wait_stall", {31'd0, stall_w}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_ResultW", ResultW, 32'd0);
    chk("abort_fResultW", fResultW, 32'd0);
    chk("abort_rd", {27'd0, rd_out}, 32'd0);
    chk("abort_strobes", {30'd0, we_out, fwe_out}, 32'd0);
    chk("abort_cnt", retire_cnt, 32'd0);
    chk("abort_stall", {31'd0, stall_w}, 32'd0);
    exp_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("post_reset_pass", {31'd0, stall_w}, 32'd0);
    o_p_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_cnt", retire_cnt, 32'd0);

    // 17 commits: the 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++)
      issue(5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 32'(i), 32'h0, 32'h0, 32'h0,
            32'(i), 32'h0, 1'b1, 1'b0);
    idle();
    @(posedge clk); #1;
    chk("cnt32_17", retire_cnt, 32'd17);
    chk("cnt4_wrap", {28'd0, retire_cnt4}, 32'd1);

    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Registered writeback stage for the pipelined RV32 core with F extension, replacing the purely combinational result select.
- Selects integer and FP results from a wider source set and sign/zero-extends load data by funct3 and byte offset.
- Holds the retiring instruction and stalls upstream while the data memory asserts o_p_waitrequest.
- Drives both register-file write ports one cycle after acceptance and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported, and the extension logic assumes 4 byte lanes.
- REG_AW, 5, register address width.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-low reset.
- valid_w  in  1  an instruction is presented to writeback this cycle.
- rd_w  in  REG_AW  destination register.
- RegWriteW  in  1  integer write enable request.
- fRegWriteW  in  1  FP write enable request.
- ResultSrcW  in  2  integer source: 00 ALU, 01 load, 10 PC+4, 11 ALU (reserved).
- fResultSrcW  in  1  FP source: 0 FPU, 1 FP load.
- funct3W  in  3  load size/sign.
- PCPlus4W, ALU_ResultW, ReadDataW, FPU_ResultW, fReadDataW  in  XLEN each  operands; ALU_ResultW[1:0] is the load byte offset.
- o_p_waitrequest  in  1  memory read data not yet valid.
- ResultW  out  XLEN  registered integer write data.
- fResultW  out  XLEN  registered FP write data.
- rd_out  out  REG_AW  registered destination.
- we_out  out  1  integer register-file write strobe.
- fwe_out  out  1  FP register-file write strobe.
- stall_w  out  1  freeze upstream stages.
- retire_cnt  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset (rst=0, asynchronous): ResultW, fResultW, rd_out and retire_cnt = 0; we_out = fwe_out = 0; FSM = PASS; hold registers cleared. stall_w = 0 while in reset.
- mem_src = (ResultSrcW==01) OR (fResultSrcW==1).
- pend = (FSM==WAIT) ? 1 : (valid_w AND mem_src).
- stall_w = pend AND o_p_waitrequest. This is combinational and must remain so, so upstream freezes in the same cycle.
- FSM PASS:
  - valid_w=1 and stall_w=0: commit at the next edge.
  - valid_w=1, mem_src=1 and o_p_waitrequest=1: capture rd_w, RegWriteW, fRegWriteW, ResultSrcW, fResultSrcW, funct3W and ALU_ResultW[1:0] into hold registers; go to WAIT; no commit.
  - valid_w=0: we_out = fwe_out = 0 next cycle.
- FSM WAIT:
  - Control comes from the hold registers; ReadDataW and fReadDataW are sampled live.
  - o_p_waitrequest=1: stay in WAIT, no commit.
  - o_p_waitrequest=0: commit at the edge and return to PASS; stall_w drops in that same cycle.
  - valid_w and the other control inputs are ignored while in WAIT.
- Commit at a clock edge:
  - ResultW <= selected integer value; fResultW <= selected FP value; rd_out <= rd.
  - we_out <= RegWrite AND (rd != 0).
  - fwe_out <= fRegWrite; FP x0 is writable.
  - retire_cnt <= retire_cnt + 1, wrapping modulo 2^CNT_W.
  - Latency: 1 cycle from acceptance to the strobe. Strobes are single-cycle pulses per commit, so back-to-back commits keep them high.
- Load extension (integer load source only; off = byte offset):
  - 000 LB: sign-extend byte lane off.
  - 001 LH: sign-extend halfword lane off[1]; off[0] is ignored.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte lane off.
  - 101 LHU: zero-extend halfword lane off[1].
  - Any other funct3: raw word.
- FP load: fReadDataW is passed unmodified, with no extension.
- Both strobes may assert in the same commit; each register file is independent.
- Reset mid-WAIT aborts the instruction: no commit, and the counter is not incremented.

Test Plan:
- ResultSrcW=00, ALU_ResultW=0x0000_1234, rd_w=5, RegWriteW=1, valid one cycle -> next cycle ResultW=0x1234, rd_out=5, we_out=1 for one cycle, retire_cnt=1.
- LB, ReadDataW=0x80FF_7F01, off=3 -> ResultW=0xFFFF_FF80; LBU off=3 -> 0x0000_0080; LH off=2 -> 0xFFFF_80FF; LHU off=1 -> 0x0000_7F01.
- Load with o_p_waitrequest high 3 cycles, then low with ReadDataW=0xDEAD_BEEF (LW) -> stall_w high exactly 3 cycles; one commit with ResultW=0xDEAD_BEEF; retire_cnt +1.
- rd_w=0 with RegWriteW=1 -> we_out stays 0 and retire_cnt increments. fRegWriteW=1, fResultSrcW=0, FPU_ResultW=0x3F80_0000, rd_w=0 -> fwe_out=1, fResultW=0x3F80_0000.
- rst pulled low during WAIT -> outputs are 0 immediately; after release no commit occurs and the FSM is in PASS. CNT_W=4 with 17 commits -> retire_cnt=1.
